// File: rtl/axi_handshake_monitor_if.sv
// VALID/READY/payload bundle for the channels watched by axi_handshake_monitor.
// The master side drives the bus and the slave side (the monitor) only observes it.
interface axi_handshake_monitor_if #(
    parameter int NUM_CH    = 5,
    parameter int PAYLOAD_W = 64
);
    logic [NUM_CH-1:0]           valid;
    logic [NUM_CH-1:0]           ready;
    logic [NUM_CH*PAYLOAD_W-1:0] payload;

    modport master (output valid, ready, payload);
    modport slave  (input  valid, ready, payload);
endinterface

// File: rtl/axi_handshake_monitor.sv
// Passive VALID/READY protocol monitor. It flags VALID drops, unstable payloads and
// stall timeouts, captures the first error and keeps a handshake count per channel.
//
// state  | meaning
// S_IDLE | no transfer outstanding on the channel
// S_WAIT | VALID seen without READY; payload captured, stall being timed
module axi_handshake_monitor #(
    parameter int NUM_CH    = 5,
    parameter int PAYLOAD_W = 64,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 16,
    parameter int CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_handshake_monitor_if.slave    bus,
    input  logic [NUM_CH-1:0]         chk_en,
    input  logic                      clr,
    output logic [NUM_CH-1:0]         err_valid_drop,
    output logic [NUM_CH-1:0]         err_unstable,
    output logic [NUM_CH-1:0]         err_timeout,
    output logic [NUM_CH*CNT_W-1:0]   hs_count,
    output logic                      first_err_vld,
    output logic [CH_IDX_W-1:0]       first_err_ch,
    output logic [1:0]                first_err_code,
    output logic                      irq
);

    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // With the check disabled the wait counter just saturates at its maximum.
    localparam logic [WCNT_W-1:0] WAIT_SAT  = (TIMEOUT > 0) ? WCNT_W'(TIMEOUT) : {WCNT_W{1'b1}};
    localparam logic [WCNT_W-1:0] WAIT_FIRE = (TIMEOUT > 0) ? WCNT_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] CODE_DROP = 2'd1;
    localparam logic [1:0] CODE_UNST = 2'd2;
    localparam logic [1:0] CODE_TO   = 2'd3;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 st_q   [NUM_CH];
    state_t                 st_d   [NUM_CH];
    logic [WCNT_W-1:0]      wcnt_q [NUM_CH];
    logic [WCNT_W-1:0]      wcnt_d [NUM_CH];
    logic [PAYLOAD_W-1:0]   cap_q  [NUM_CH];
    logic [PAYLOAD_W-1:0]   cap_d  [NUM_CH];
    logic [PAYLOAD_W-1:0]   pl_ch  [NUM_CH];

    logic [NUM_CH-1:0]      hs_ev;
    logic [NUM_CH-1:0]      set_drop;
    logic [NUM_CH-1:0]      set_unst;
    logic [NUM_CH-1:0]      set_to;

    logic [NUM_CH-1:0]      drop_d;
    logic [NUM_CH-1:0]      unst_d;
    logic [NUM_CH-1:0]      to_d;
    logic [NUM_CH*CNT_W-1:0] hs_count_d;
    logic                   fe_vld_d;
    logic [CH_IDX_W-1:0]    fe_ch_d;
    logic [1:0]             fe_code_d;
    logic                   irq_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pl_ch[i] = bus.payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= S_IDLE;
                wcnt_q[i] <= '0;
                cap_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]   <= st_d[i];
                wcnt_q[i] <= wcnt_d[i];
                cap_q[i]  <= cap_d[i];
            end
        end
    end

    always_comb begin
        hs_ev    = '0;
        set_drop = '0;
        set_unst = '0;
        set_to   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]   = st_q[i];
            wcnt_d[i] = wcnt_q[i];
            cap_d[i]  = cap_q[i];
            if (!chk_en[i]) begin
                st_d[i]   = S_IDLE;
                wcnt_d[i] = '0;
            end else begin
                case (st_q[i])
                    S_IDLE: begin
                        if (bus.valid[i] && bus.ready[i]) begin
                            hs_ev[i] = 1'b1;
                        end else if (bus.valid[i]) begin
                            cap_d[i]  = pl_ch[i];
                            wcnt_d[i] = WCNT_W'(1);
                            st_d[i]   = S_WAIT;
                            set_to[i] = (TIMEOUT == 1);
                        end
                    end
                    S_WAIT: begin
                        if (!bus.valid[i]) begin
                            set_drop[i] = 1'b1;
                            wcnt_d[i]   = '0;
                            st_d[i]     = S_IDLE;
                        end else begin
                            set_unst[i] = (pl_ch[i] != cap_q[i]);
                            if (bus.ready[i]) begin
                                hs_ev[i]  = 1'b1;
                                wcnt_d[i] = '0;
                                st_d[i]   = S_IDLE;
                            end else if (wcnt_q[i] != WAIT_SAT) begin
                                wcnt_d[i] = wcnt_q[i] + WCNT_W'(1);
                                set_to[i] = (TIMEOUT > 0) && (wcnt_q[i] == WAIT_FIRE);
                            end
                        end
                    end
                    default: begin
                        st_d[i]   = S_IDLE;
                        wcnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // clr and a same-edge violation combine: the clear applies first, the new event on top.
    always_comb begin
        drop_d     = (clr ? '0 : err_valid_drop) | set_drop;
        unst_d     = (clr ? '0 : err_unstable)   | set_unst;
        to_d       = (clr ? '0 : err_timeout)    | set_to;
        hs_count_d = clr ? '0 : hs_count;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hs_ev[i] && (hs_count_d[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                hs_count_d[i*CNT_W +: CNT_W] = hs_count_d[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end

        fe_vld_d  = first_err_vld & ~clr;
        fe_ch_d   = clr ? '0 : first_err_ch;
        fe_code_d = clr ? '0 : first_err_code;
        if (!fe_vld_d && (|{set_drop, set_unst, set_to})) begin
            fe_vld_d = 1'b1;
            // Descending scan so the lowest channel index is the final assignment.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (set_drop[i] || set_unst[i] || set_to[i]) begin
                    fe_ch_d = CH_IDX_W'(i);
                    if (set_drop[i]) begin
                        fe_code_d = CODE_DROP;
                    end else if (set_unst[i]) begin
                        fe_code_d = CODE_UNST;
                    end else begin
                        fe_code_d = CODE_TO;
                    end
                end
            end
        end

        irq_d = (|drop_d) | (|unst_d) | (|to_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_valid_drop <= '0;
            err_unstable   <= '0;
            err_timeout    <= '0;
            hs_count       <= '0;
            first_err_vld  <= 1'b0;
            first_err_ch   <= '0;
            first_err_code <= '0;
            irq            <= 1'b0;
        end else begin
            err_valid_drop <= drop_d;
            err_unstable   <= unst_d;
            err_timeout    <= to_d;
            hs_count       <= hs_count_d;
            first_err_vld  <= fe_vld_d;
            first_err_ch   <= fe_ch_d;
            first_err_code <= fe_code_d;
            irq            <= irq_d;
        end
    end

endmodule

// File: doc/axi_handshake_monitor.md
Name: axi_handshake_monitor

Overview:
Synthesizable, parametrised protocol monitor for an arbitrary number of AXI/AXI-Lite VALID/READY channels. It is the hardware successor to the bridge's simulation-only assertion checker. It sits passively on the s_axi_* and m_axil_* channels of the bridge and checks three rules per channel: VALID held until handshake, payload stable while stalled, and bounded VALID-to-READY wait. Violations are reported as sticky flags, a first-error capture register and an interrupt line, alongside per-channel handshake counters.

Parameters:
NUM_CH, 5, number of monitored channels (1..32)
PAYLOAD_W, 64, payload bits per channel (address/data/resp/id, zero-padded by instantiator)
TIMEOUT, 16, stalled cycles before timeout error; 0 disables timeout check
CNT_W, 16, width of each handshake counter
CH_IDX_W, $clog2(NUM_CH) min 1, derived; width of channel index

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
valid  in  NUM_CH  VALID of each channel
ready  in  NUM_CH  READY of each channel
payload  in  NUM_CH*PAYLOAD_W  packed payloads, channel i at [i*PAYLOAD_W +: PAYLOAD_W]
chk_en  in  NUM_CH  per-channel check enable
clr  in  1  synchronous clear pulse for flags, capture and counters
err_valid_drop  out  NUM_CH  sticky: VALID dropped before handshake
err_unstable  out  NUM_CH  sticky: payload changed while stalled
err_timeout  out  NUM_CH  sticky: stall reached TIMEOUT cycles
hs_count  out  NUM_CH*CNT_W  saturating handshake count per channel
first_err_vld  out  1  first-error capture valid
first_err_ch  out  CH_IDX_W  channel of first error
first_err_code  out  2  1=valid_drop, 2=unstable, 3=timeout (0 unused)
irq  out  1  OR of all sticky error flags

Behaviour:
- Reset (rst low, async): all outputs 0; every channel FSM in IDLE; wait counters and captured payloads 0.
- Per channel FSM, evaluated on each rising edge with sampled inputs:
  - IDLE:
    - valid&ready -> handshake; hs_count+1; stay IDLE.
    - valid&!ready -> capture payload, wait_cnt=1 -> WAIT.
    - !valid -> stay.
  - WAIT:
    - valid&ready -> handshake; if payload!=captured, set err_unstable; hs_count+1 -> IDLE.
    - valid&!ready -> if payload!=captured, set err_unstable; wait_cnt+1 (saturating at TIMEOUT); if the new wait_cnt==TIMEOUT, set err_timeout; stay WAIT.
    - !valid -> set err_valid_drop -> IDLE.
- Timeout firing: err_timeout fires once per stall episode, at the edge that samples the TIMEOUT-th consecutive stalled cycle.
- Flag latency: flags and counters update on the edge that samples the violation and are visible immediately after it. No combinational paths from inputs to outputs.
- Stickiness: flags stay set until clr or reset; subsequent violations on a set flag have no effect.
- hs_count saturates at all-ones and never wraps.
- chk_en[i]=0: channel i forced to IDLE, wait_cnt cleared, no flags set, no counting. Existing flags and counts are held. Re-enable starts in IDLE, so a VALID already high is treated as a new transfer.
- First-error capture: loads on the first edge at which any new flag sets while first_err_vld=0. Priority is lowest channel index, then code valid_drop > unstable > timeout. Held until clr.
- clr:
  - Clears all flags, hs_count, first_err_*.
  - Does not change FSM state or wait_cnt.
  - A violation sampled on the same edge as clr wins: its flag sets, first error captures it, and the same-edge handshake counts as 1.
- irq is a registered OR of all three flag vectors, same cycle as the flags.
- TIMEOUT=0: wait_cnt still tracked, err_timeout never set.

Test Plan:
1. NUM_CH=5, TIMEOUT=4; ch0 valid=1 with ready=1 for 3 cycles -> hs_count[0]=3, all flags 0, irq=0.
2. ch2 valid=1, ready=0 for 4 cycles, payload constant -> err_timeout[2]=1 after 4th edge (not 3rd), first_err_ch=2, code=3, irq=1; holding the stall 10 more cycles leaves flags and capture unchanged.
3. ch1 valid=1, ready=0, payload 0x1234 then 0x5678 next cycle -> err_unstable[1]=1, code=2. Then pulse clr -> all flags, counts and first_err_vld return to 0.
4. Same edge: ch3 drops VALID while stalled and ch1 payload changes while stalled -> both flags set; first_err_ch=1, code=2.
5. chk_en[4]=0, then ch4 stalls 20 cycles and drops VALID -> no ch4 flags, hs_count[4] unchanged. Re-enable with valid=1, ready=1 -> hs_count[4]+1.
6. CNT_W=2; 5 handshakes on ch0 -> hs_count[0]=3 (saturated). Assert rst low mid-stall -> all outputs 0 asynchronously, FSM IDLE after release.
